// File: rtl/demux1to8_hold_pkg.sv
// Shared constants for the 1-to-8 holding demultiplexer: channel count,
// select width, default word MSB and the channel index names.
package demux1to8_hold_pkg;

  localparam int NCH       = 8;
  localparam int SEL_W     = 3;
  localparam int N_DEFAULT = 3;

  typedef enum logic [SEL_W-1:0] {
    CH_A = 3'd0,
    CH_B = 3'd1,
    CH_C = 3'd2,
    CH_D = 3'd3,
    CH_E = 3'd4,
    CH_F = 3'd5,
    CH_G = 3'd6,
    CH_H = 3'd7
  } chan_e;

  function automatic logic [NCH-1:0] chanOnehot(input logic [SEL_W-1:0] sel);
    return NCH'(1) << sel;
  endfunction

endpackage

// File: rtl/demux1to8_hold_chan_reg.sv
// One holding register with its valid flag; a write wins over a same-cycle
// ack so a channel can be drained and refilled back to back.
module demux_chan_reg #(
  parameter int N = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_wr_en,
  input  logic [N:0] i_din,
  input  logic       i_ack,
  output logic [N:0] o_q,
  output logic       o_valid
);

  logic [N:0] r_q;
  logic       r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q     <= '0;
      r_valid <= 1'b0;
    end else if (i_wr_en) begin
      r_q     <= i_din;
      r_valid <= 1'b1;
    end else if (i_ack) begin
      r_valid <= 1'b0;
    end
  end

  assign o_q     = r_q;
  assign o_valid = r_valid;

endmodule

// File: rtl/demux1to8_hold.sv
// Registered 1-to-8 demultiplexer: routes each accepted word to one of eight
// holding registers chosen by the select bits or by the internal scan pointer.
module demux1to8_hold
  import demux1to8_hold_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N:0]     i_din,
  input  logic           i_s0,
  input  logic           i_s1,
  input  logic           i_s2,
  input  logic           i_seq_mode,
  input  logic           i_in_valid,
  output logic           o_in_ready,
  output logic [N:0]     o_a,
  output logic [N:0]     o_b,
  output logic [N:0]     o_c,
  output logic [N:0]     o_d,
  output logic [N:0]     o_e,
  output logic [N:0]     o_f,
  output logic [N:0]     o_g,
  output logic [N:0]     o_h,
  output logic [NCH-1:0] o_out_valid,
  input  logic [NCH-1:0] i_out_ack,
  output logic [SEL_W-1:0] o_ptr,
  output logic           o_frame_done
);

  logic [SEL_W-1:0] r_ptr;
  logic             r_frameDone;

  logic [SEL_W-1:0] w_sel;
  logic             w_accept;
  logic [NCH-1:0]   w_wrEn;
  logic [NCH-1:0]   w_valid;
  logic [N:0]       w_q [NCH];

  // A channel being acked this cycle counts as free, enabling same-cycle refill.
  assign w_sel      = i_seq_mode ? r_ptr : {i_s2, i_s1, i_s0};
  assign o_in_ready = ~w_valid[w_sel] | i_out_ack[w_sel];
  assign w_accept   = i_in_valid & o_in_ready;
  assign w_wrEn     = w_accept ? chanOnehot(w_sel) : '0;

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    demux_chan_reg #(.N(N)) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_wr_en (w_wrEn[k]),
      .i_din   (i_din),
      .i_ack   (i_out_ack[k]),
      .o_q     (w_q[k]),
      .o_valid (w_valid[k])
    );
  end

  // The pointer only moves on accepted words in scan mode and is never
  // disturbed by toggling the mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= w_accept & i_seq_mode & (r_ptr == CH_H);
      if (w_accept && i_seq_mode) begin
        r_ptr <= r_ptr + 1'b1;
      end
    end
  end

  assign o_a          = w_q[CH_A];
  assign o_b          = w_q[CH_B];
  assign o_c          = w_q[CH_C];
  assign o_d          = w_q[CH_D];
  assign o_e          = w_q[CH_E];
  assign o_f          = w_q[CH_F];
  assign o_g          = w_q[CH_G];
  assign o_h          = w_q[CH_H];
  assign o_out_valid  = w_valid;
  assign o_ptr        = r_ptr;
  assign o_frame_done = r_frameDone;

endmodule

// File: tb/tb_demux1to8_hold.sv
// Self-checking bench: a channel-array reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_demux1to8_hold;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [N:0] din = '0;
  logic       s0 = 1'b0, s1 = 1'b0, s2 = 1'b0;
  logic       seqMode = 1'b0;
  logic       inValid = 1'b0;
  logic [7:0] outAck = '0;
  logic       inReady;
  logic [N:0] a, b, c, d, e, f, g, h;
  logic [7:0] outValid;
  logic [2:0] ptr;
  logic       frameDone;

  logic [N:0] dutReg [8];

  int checks = 0;
  int errors = 0;

  logic [N:0] mReg [8];
  logic [7:0] mValid = '0;
  int         mPtr = 0;
  logic       mFd = 1'b0;
  int         mSel;
  bit         mAcc;

  demux1to8_hold #(.N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_din        (din),
    .i_s0         (s0),
    .i_s1         (s1),
    .i_s2         (s2),
    .i_seq_mode   (seqMode),
    .i_in_valid   (inValid),
    .o_in_ready   (inReady),
    .o_a          (a),
    .o_b          (b),
    .o_c          (c),
    .o_d          (d),
    .o_e          (e),
    .o_f          (f),
    .o_g          (g),
    .o_h          (h),
    .o_out_valid  (outValid),
    .i_out_ack    (outAck),
    .o_ptr        (ptr),
    .o_frame_done (frameDone)
  );

  always #5 clk = ~clk;

  assign dutReg[0] = a;
  assign dutReg[1] = b;
  assign dutReg[2] = c;
  assign dutReg[3] = d;
  assign dutReg[4] = e;
  assign dutReg[5] = f;
  assign dutReg[6] = g;
  assign dutReg[7] = h;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic sm, input logic [2:0] sel,
                               input logic [N:0] dv, input logic [7:0] ack);
    @(negedge clk);
    inValid = v;
    seqMode = sm;
    {s2, s1, s0} = sel;
    din = dv;
    outAck = ack;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 3'd0, '0, 8'h00);
  endtask

  // Reference model: eight slots with full flags and a wrapping scan index.
  initial begin
    for (int k = 0; k < 8; k++) mReg[k] = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < 8; k++) mReg[k] = '0;
        mValid = '0;
        mPtr = 0;
        mFd = 1'b0;
      end else begin
        mSel = seqMode ? mPtr : int'({s2, s1, s0});
        mAcc = inValid && (!mValid[mSel] || outAck[mSel]);
        mValid = mValid & ~outAck;
        mFd = 1'b0;
        if (mAcc) begin
          mReg[mSel] = din;
          mValid[mSel] = 1'b1;
          if (seqMode) begin
            mFd = (mPtr == 7);
            mPtr = (mPtr + 1) % 8;
          end
        end
      end
    end
  end

  initial begin
    int sel;
    forever begin
      @(posedge clk);
      #3;
      for (int k = 0; k < 8; k++)
        checkOutput($sformatf("cyc_reg%0d", k), 32'(dutReg[k]), 32'(mReg[k]));
      checkOutput("cyc_valid", 32'(outValid), 32'(mValid));
      checkOutput("cyc_ptr", 32'(ptr), 32'(mPtr));
      checkOutput("cyc_frame_done", 32'(frameDone), 32'(mFd));
      sel = seqMode ? mPtr : int'({s2, s1, s0});
      checkOutput("cyc_in_ready", 32'(inReady), 32'(!mValid[sel] || outAck[sel]));
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 8; k++) checkOutput($sformatf("por_reg%0d", k), 32'(dutReg[k]), 0);
    checkOutput("por_valid", 32'(outValid), 0);
    checkOutput("por_ptr", 32'(ptr), 0);
    checkOutput("por_frame_done", 32'(frameDone), 0);
    rst_n = 1'b1;

    // Mid-stream reset with every channel full and ptr parked at 5
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b1, 3'd0, 4'(k + 1), 8'h00);
    for (int k = 5; k < 8; k++) applyStimulus(1'b1, 1'b0, 3'(k), 4'(k + 1), 8'h00);
    idle();
    #1;
    checkOutput("pre_rst_valid", 32'(outValid), 32'hFF);
    checkOutput("pre_rst_ptr", 32'(ptr), 5);
    checkOutput("pre_rst_h", 32'(h), 8);
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) checkOutput($sformatf("rst_reg%0d", k), 32'(dutReg[k]), 0);
    checkOutput("rst_valid", 32'(outValid), 0);
    checkOutput("rst_ptr", 32'(ptr), 0);
    checkOutput("rst_frame_done", 32'(frameDone), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Direct select to channel f
    applyStimulus(1'b1, 1'b0, 3'b101, 4'hA, 8'h00);
    idle();
    #1;
    for (int k = 0; k < 8; k++)
      checkOutput($sformatf("direct_reg%0d", k), 32'(dutReg[k]), (k == 5) ? 32'hA : 0);
    checkOutput("direct_valid", 32'(outValid), 32'h20);

    // Backpressure on channel c, then same-cycle ack and refill
    applyStimulus(1'b1, 1'b0, 3'd2, 4'h3, 8'h00);
    applyStimulus(1'b1, 1'b0, 3'd2, 4'h7, 8'h00);
    #1;
    checkOutput("bp_ready_blocked", 32'(inReady), 0);
    applyStimulus(1'b1, 1'b0, 3'd2, 4'h7, 8'h04);
    #1;
    checkOutput("bp_c_held", 32'(c), 3);
    checkOutput("bp_ready_acked", 32'(inReady), 1);
    idle();
    #1;
    checkOutput("bp_c_refilled", 32'(c), 7);
    checkOutput("bp_valid", 32'(outValid), 32'h24);

    // Scan mode with acks tied high
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, 1'b1, 3'd0, 4'(k + 1), 8'hFF);
    idle();
    #1;
    for (int k = 0; k < 8; k++) checkOutput($sformatf("scan_reg%0d", k), 32'(dutReg[k]), k + 1);
    checkOutput("scan_ptr_wrap", 32'(ptr), 0);
    checkOutput("scan_frame_done_hi", 32'(frameDone), 1);
    checkOutput("scan_valid", 32'(outValid), 32'h80);
    idle();
    #1;
    checkOutput("scan_frame_done_lo", 32'(frameDone), 0);

    // Simultaneous acks on a full bank, then an ack on an empty channel
    applyStimulus(1'b0, 1'b0, 3'd0, '0, 8'h80);
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, 1'b1, 3'd0, 4'(15 - k), 8'h00);
    idle();
    #1;
    checkOutput("full_valid", 32'(outValid), 32'hFF);
    applyStimulus(1'b0, 1'b0, 3'd0, '0, 8'h81);
    idle();
    #1;
    checkOutput("acks_valid", 32'(outValid), 32'h7E);
    checkOutput("acks_a_kept", 32'(a), 32'hF);
    checkOutput("acks_h_kept", 32'(h), 32'h8);
    applyStimulus(1'b0, 1'b0, 3'd0, '0, 8'h01);
    idle();
    #1;
    checkOutput("empty_ack_valid", 32'(outValid), 32'h7E);
    checkOutput("empty_ack_a", 32'(a), 32'hF);

    // Mode switch: ptr survives a detour through direct select
    applyStimulus(1'b0, 1'b0, 3'd0, '0, 8'hFF);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1, 3'd0, 4'(k + 1), 8'h00);
    idle();
    #1;
    checkOutput("mode_ptr3", 32'(ptr), 3);
    applyStimulus(1'b1, 1'b0, 3'd6, 4'h5, 8'h00);
    idle();
    #1;
    checkOutput("mode_g", 32'(g), 5);
    checkOutput("mode_ptr_held", 32'(ptr), 3);
    checkOutput("mode_valid_direct", 32'(outValid), 32'h47);
    applyStimulus(1'b1, 1'b1, 3'd0, 4'h9, 8'h00);
    idle();
    #1;
    checkOutput("mode_d", 32'(d), 9);
    checkOutput("mode_ptr4", 32'(ptr), 4);
    checkOutput("mode_valid_scan", 32'(outValid), 32'h4F);

    repeat (2) idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
